// File: rtl/key_text_pkg.sv
// Shared types and constants for the PS/2 keyboard text buffer.
package key_text_pkg;

    // Scancode prefix decoder states
    typedef enum logic [1:0] {
        D_IDLE    = 2'd0,
        D_BREAK   = 2'd1,
        D_EXT     = 2'd2,
        D_EXT_BRK = 2'd3
    } dec_state_t;

    // Buffer operation queued by the decoder, executed one cycle later
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_CHAR  = 3'd1,
        CMD_BKSP  = 3'd2,
        CMD_ENTER = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_t;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic is_shift(input logic [7:0] sc);
        return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational PS/2 set-2 make code to ASCII lookup (letters, digits, space).
module ps2_scancode_map
    import key_text_pkg::*;
(
    input  logic [7:0] i_scancode,
    input  logic       i_shift,
    output logic [7:0] o_ascii
);

    logic [7:0] w_lower;

    // Base (unshifted) character, then upper-case letters when shift is held
    always_comb begin
        w_lower = 8'h00;
        case (i_scancode)
            8'h1C: w_lower = 8'h61; 8'h32: w_lower = 8'h62; 8'h21: w_lower = 8'h63;
            8'h23: w_lower = 8'h64; 8'h24: w_lower = 8'h65; 8'h2B: w_lower = 8'h66;
            8'h34: w_lower = 8'h67; 8'h33: w_lower = 8'h68; 8'h43: w_lower = 8'h69;
            8'h3B: w_lower = 8'h6A; 8'h42: w_lower = 8'h6B; 8'h4B: w_lower = 8'h6C;
            8'h3A: w_lower = 8'h6D; 8'h31: w_lower = 8'h6E; 8'h44: w_lower = 8'h6F;
            8'h4D: w_lower = 8'h70; 8'h15: w_lower = 8'h71; 8'h2D: w_lower = 8'h72;
            8'h1B: w_lower = 8'h73; 8'h2C: w_lower = 8'h74; 8'h3C: w_lower = 8'h75;
            8'h2A: w_lower = 8'h76; 8'h1D: w_lower = 8'h77; 8'h22: w_lower = 8'h78;
            8'h35: w_lower = 8'h79; 8'h1A: w_lower = 8'h7A;
            8'h45: w_lower = 8'h30; 8'h16: w_lower = 8'h31; 8'h1E: w_lower = 8'h32;
            8'h26: w_lower = 8'h33; 8'h25: w_lower = 8'h34; 8'h2E: w_lower = 8'h35;
            8'h36: w_lower = 8'h36; 8'h3D: w_lower = 8'h37; 8'h3E: w_lower = 8'h38;
            8'h46: w_lower = 8'h39;
            8'h29: w_lower = ASCII_SPACE;
            default: w_lower = 8'h00;
        endcase
        o_ascii = w_lower;
        if (i_shift && (w_lower >= 8'h61) && (w_lower <= 8'h7A)) begin
            o_ascii = w_lower - 8'h20;
        end
    end

endmodule

// File: rtl/key_text_buffer.sv
// PS/2 keyboard text buffer: decodes set-2 scancodes and edits a COLS x ROWS
// character array with a cursor; two asynchronous read ports for display/CPU.
module key_text_buffer
    import key_text_pkg::*;
#(
    parameter  int COLS      = 12,
    parameter  int ROWS      = 9,
    parameter  int FULL_MODE = 0,
    localparam int CELLS     = COLS * ROWS,
    localparam int AW        = $clog2(CELLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          read_data,
    input  logic          err,
    input  logic          clear,
    input  logic [AW-1:0] disp_addr,
    output logic [7:0]    disp_char,
    input  logic [AW-1:0] cpu_addr,
    output logic [7:0]    cpu_char,
    output logic [AW-1:0] cursor,
    output logic          key_valid,
    output logic [7:0]    key_ascii,
    output logic          full,
    output logic [7:0]    err_count
);

    // Cursor arithmetic is widened by one bit so CELLS need not be a power of two
    localparam int            AWP      = AW + 1;
    localparam logic [AW:0]   L_CELLS  = AWP'(CELLS);
    localparam logic [AW:0]   L_COLS   = AWP'(COLS);
    localparam logic [AW-1:0] LAST_IDX = AW'(CELLS - 1);

    dec_state_t    r_state;
    logic          r_shift;
    logic [7:0]    r_err_count;
    cmd_t          r_cmd;
    logic [7:0]    r_cmd_char;
    logic [AW-1:0] r_cursor;
    logic          r_key_valid;
    logic [7:0]    r_key_ascii;

    logic [7:0]    w_map_ascii;
    logic [7:0]    w_cells [CELLS];
    logic          w_full;
    logic [AW:0]   w_cur_ext;
    logic [AW:0]   w_step;
    logic          w_adv;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_wr_data;
    logic [AW-1:0] w_cursor_next;
    logic          w_key_valid_next;

    ps2_scancode_map u_map (
        .i_scancode (rx_data),
        .i_shift    (r_shift),
        .o_ascii    (w_map_ascii)
    );

    // Decoder: follows F0/E0 prefixes, tracks shift and errors, queues one command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= D_IDLE;
            r_shift     <= 1'b0;
            r_err_count <= 8'h00;
            r_cmd       <= CMD_NONE;
            r_cmd_char  <= 8'h00;
        end else begin
            r_cmd <= CMD_NONE;
            if (read_data) begin
                if (err) begin
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_state <= D_IDLE;
                end else begin
                    r_state <= D_IDLE;
                    case (r_state)
                        D_IDLE: begin
                            if (rx_data == SC_BREAK) begin
                                r_state <= D_BREAK;
                            end else if (rx_data == SC_EXT) begin
                                r_state <= D_EXT;
                            end else if (is_shift(rx_data)) begin
                                r_shift <= 1'b1;
                            end else if (rx_data == SC_BKSP) begin
                                r_cmd <= CMD_BKSP;
                            end else if (rx_data == SC_ENTER) begin
                                r_cmd <= CMD_ENTER;
                            end else if (w_map_ascii != 8'h00) begin
                                r_cmd      <= CMD_CHAR;
                                r_cmd_char <= w_map_ascii;
                            end
                        end
                        D_BREAK: begin
                            if (is_shift(rx_data)) begin
                                r_shift <= 1'b0;
                            end
                        end
                        D_EXT: begin
                            if (rx_data == SC_BREAK) begin
                                r_state <= D_EXT_BRK;
                            end else if (rx_data == SC_LEFT) begin
                                r_cmd <= CMD_LEFT;
                            end else if (rx_data == SC_RIGHT) begin
                                r_cmd <= CMD_RIGHT;
                            end
                        end
                        D_EXT_BRK: begin
                            // extended break codes carry no action
                        end
                    endcase
                end
            end
        end
    end

    assign w_full = (r_cursor == LAST_IDX) && (w_cells[CELLS-1] != ASCII_SPACE);

    // Execute the queued command: buffer write port and next cursor position
    always_comb begin
        w_cur_ext        = {1'b0, r_cursor};
        w_step           = '0;
        w_adv            = 1'b0;
        w_wr_en          = 1'b0;
        w_wr_addr        = r_cursor;
        w_wr_data        = ASCII_SPACE;
        w_cursor_next    = r_cursor;
        w_key_valid_next = 1'b0;
        case (r_cmd)
            CMD_CHAR: begin
                if (!((FULL_MODE != 0) && w_full)) begin
                    w_wr_en          = 1'b1;
                    w_wr_data        = r_cmd_char;
                    w_key_valid_next = 1'b1;
                    w_step           = w_cur_ext + AWP'(1);
                    w_adv            = 1'b1;
                end
            end
            CMD_ENTER: begin
                w_step = w_cur_ext - (w_cur_ext % L_COLS) + L_COLS;
                w_adv  = 1'b1;
            end
            CMD_BKSP: begin
                if (r_cursor != '0) begin
                    w_cursor_next = r_cursor - AW'(1);
                    w_wr_en       = 1'b1;
                    w_wr_addr     = r_cursor - AW'(1);
                end
            end
            CMD_LEFT: begin
                if (r_cursor != '0) begin
                    w_cursor_next = r_cursor - AW'(1);
                end
            end
            CMD_RIGHT: begin
                if ((w_cur_ext + AWP'(1)) < L_CELLS) begin
                    w_cursor_next = r_cursor + AW'(1);
                end
            end
            default: begin
            end
        endcase
        if (w_adv) begin
            if (w_step >= L_CELLS) begin
                w_cursor_next = (FULL_MODE != 0) ? LAST_IDX : '0;
            end else begin
                w_cursor_next = w_step[AW-1:0];
            end
        end
    end

    // Cursor and key strobe; clear overrides any queued command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cursor    <= '0;
            r_key_valid <= 1'b0;
            r_key_ascii <= 8'h00;
        end else if (clear) begin
            r_cursor    <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_cursor    <= w_cursor_next;
            r_key_valid <= w_key_valid_next;
            if (w_key_valid_next) begin
                r_key_ascii <= w_wr_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [7:0] r_cell;
            // One character cell: reset/clear to space, else single write port
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cell <= ASCII_SPACE;
                end else if (clear) begin
                    r_cell <= ASCII_SPACE;
                end else if (w_wr_en && (w_wr_addr == AW'(gi))) begin
                    r_cell <= w_wr_data;
                end
            end
            assign w_cells[gi] = r_cell;
        end
    endgenerate

    assign disp_char = w_cells[disp_addr];
    assign cpu_char  = w_cells[cpu_addr];
    assign cursor    = r_cursor;
    assign key_valid = r_key_valid;
    assign key_ascii = r_key_ascii;
    assign full      = w_full;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_key_text_buffer.sv
// Randomized and directed checks of key_text_buffer (both FULL_MODE settings)
// against a transaction-level model of the editing rules.
module tb_key_text_buffer;

    localparam int COLS  = 12;
    localparam int ROWS  = 9;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [7:0] LETTERS [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rx_data;
    logic read_data, err, clear;
    logic [AW-1:0] disp_addr, cpu_addr;

    logic [1:0][7:0]    o_disp, o_cpu, o_ascii, o_errc;
    logic [1:0][AW-1:0] o_cur;
    logic [1:0]         o_kv, o_full;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [7:0] m_mem [2][CELLS];
    int         m_cur [2];
    logic [7:0] m_ascii [2];
    bit         m_kv [2];
    bit         m_shift, m_brk, m_ext;
    int         m_errc;

    always #5 clk = ~clk;

    key_text_buffer #(.COLS(COLS), .ROWS(ROWS), .FULL_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data), .err(err),
        .clear(clear), .disp_addr(disp_addr), .disp_char(o_disp[0]), .cpu_addr(cpu_addr),
        .cpu_char(o_cpu[0]), .cursor(o_cur[0]), .key_valid(o_kv[0]), .key_ascii(o_ascii[0]),
        .full(o_full[0]), .err_count(o_errc[0]));

    key_text_buffer #(.COLS(COLS), .ROWS(ROWS), .FULL_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data), .err(err),
        .clear(clear), .disp_addr(disp_addr), .disp_char(o_disp[1]), .cpu_addr(cpu_addr),
        .cpu_char(o_cpu[1]), .cursor(o_cur[1]), .key_valid(o_kv[1]), .key_ascii(o_ascii[1]),
        .full(o_full[1]), .err_count(o_errc[1]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_map(input logic [7:0] sc, input bit sh);
        for (int i = 0; i < 26; i++) if (sc == LETTERS[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++) if (sc == DIGITS[i]) return 8'h30 + 8'(i);
        if (sc == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    function automatic bit model_full(input int d);
        return (m_cur[d] == CELLS - 1) && (m_mem[d][CELLS-1] != 8'h20);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CELLS; i++) m_mem[d][i] = 8'h20;
            m_cur[d] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int d = 0; d < 2; d++) begin
            m_ascii[d] = 8'h00;
            m_kv[d]    = 1'b0;
        end
        m_shift = 0; m_brk = 0; m_ext = 0; m_errc = 0;
    endtask

    task automatic model_write(input int d, input logic [7:0] c);
        if (d == 1 && model_full(d)) return;
        m_mem[d][m_cur[d]] = c;
        m_kv[d]    = 1'b1;
        m_ascii[d] = c;
        if (m_cur[d] == CELLS - 1) m_cur[d] = (d == 1) ? CELLS - 1 : 0;
        else m_cur[d]++;
    endtask

    task automatic model_enter(input int d);
        int r;
        r = (m_cur[d] / COLS + 1) * COLS;
        if (r >= CELLS) m_cur[d] = (d == 1) ? CELLS - 1 : 0;
        else m_cur[d] = r;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit e, input bit clr);
        logic [7:0] c;
        m_kv[0] = 0; m_kv[1] = 0;
        if (e) begin
            if (m_errc < 255) m_errc++;
            m_brk = 0; m_ext = 0;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_brk && !m_ext && b == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (m_brk) begin
                if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = 0;
            end else if (m_ext) begin
                if (!clr) for (int d = 0; d < 2; d++) begin
                    if (b == 8'h6B && m_cur[d] > 0) m_cur[d]--;
                    if (b == 8'h74 && m_cur[d] < CELLS - 1) m_cur[d]++;
                end
            end else if (b == 8'h12 || b == 8'h59) begin
                m_shift = 1;
            end else if (!clr) begin
                for (int d = 0; d < 2; d++) begin
                    if (b == 8'h66) begin
                        if (m_cur[d] > 0) begin
                            m_cur[d]--;
                            m_mem[d][m_cur[d]] = 8'h20;
                        end
                    end else if (b == 8'h5A) begin
                        model_enter(d);
                    end else begin
                        c = ref_map(b, m_shift);
                        if (c != 8'h00) model_write(d, c);
                    end
                end
            end
            m_brk = 0; m_ext = 0;
        end
        if (clr) model_clear();
    endtask

    // ---------------- stimulus/check helpers ----------------
    task automatic check_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_cursor%0d", tag, d), 32'(o_cur[d]), 32'(m_cur[d]));
            check_eq($sformatf("%s_full%0d", tag, d), 32'(o_full[d]), 32'(model_full(d)));
            check_eq($sformatf("%s_kv%0d", tag, d), 32'(o_kv[d]), 32'(m_kv[d]));
            check_eq($sformatf("%s_ascii%0d", tag, d), 32'(o_ascii[d]), 32'(m_ascii[d]));
            check_eq($sformatf("%s_errc%0d", tag, d), 32'(o_errc[d]), 32'(m_errc));
        end
    endtask

    task automatic scan_cells(input string tag);
        for (int i = 0; i < CELLS; i++) begin
            disp_addr = AW'(i);
            cpu_addr  = AW'(CELLS - 1 - i);
            #1;
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("%s_disp%0d[%0d]", tag, d, i), 32'(o_disp[d]), 32'(m_mem[d][i]));
                check_eq($sformatf("%s_cpu%0d[%0d]", tag, d, CELLS - 1 - i), 32'(o_cpu[d]),
                         32'(m_mem[d][CELLS-1-i]));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e, input bit clr);
        model_byte(b, e, clr);
        @(negedge clk);
        rx_data = b; read_data = 1'b1; err = e;
        @(negedge clk);
        read_data = 1'b0; err = 1'b0; rx_data = 8'($urandom); clear = clr;
        check_eq("kv_early0", 32'(o_kv[0]), 32'd0);
        check_eq("kv_early1", 32'(o_kv[1]), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check_outputs($sformatf("byte%02h", b));
        $display("[TB] byte=%02h err=%0d clr=%0d cur0=%0d cur1=%0d kv=%b%b ascii=%02h/%02h",
                 b, e, clr, o_cur[0], o_cur[1], o_kv[1], o_kv[0], o_ascii[0], o_ascii[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs("reset");
        $display("[TB] reset");
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        m_kv[0] = 0; m_kv[1] = 0;
        check_outputs("clear");
        $display("[TB] clear");
    endtask

    function automatic logic [7:0] rand_byte();
        int r, k;
        r = $urandom_range(0, 99);
        if (r < 45) begin
            k = $urandom_range(0, 36);
            if (k < 26) return LETTERS[k];
            if (k < 36) return DIGITS[k-26];
            return 8'h29;
        end
        if (r < 52) return 8'hF0;
        if (r < 57) return 8'hE0;
        if (r < 62) return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        if (r < 70) return 8'h66;
        if (r < 76) return 8'h5A;
        if (r < 82) return 8'h6B;
        if (r < 88) return 8'h74;
        return 8'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; read_data = 1'b0; err = 1'b0; clear = 1'b0;
        disp_addr = '0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs("por");
        scan_cells("por");

        // make/break of a letter
        send_byte(8'h1C, 0, 0); send_byte(8'hF0, 0, 0); send_byte(8'h1C, 0, 0);
        disp_addr = '0; #1;
        check_eq("s1_cell0", 32'(o_disp[0]), 32'h61);
        check_eq("s1_cursor", 32'(o_cur[0]), 32'd1);

        // shift selects upper case until its break
        do_reset();
        send_byte(8'h12, 0, 0); send_byte(8'h1C, 0, 0); send_byte(8'hF0, 0, 0);
        send_byte(8'h12, 0, 0); send_byte(8'h1C, 0, 0);
        disp_addr = AW'(0); cpu_addr = AW'(1); #1;
        check_eq("s2_cell0", 32'(o_disp[0]), 32'h41);
        check_eq("s2_cell1", 32'(o_cpu[0]), 32'h61);

        // backspace, including the no-op at cursor 0
        do_reset();
        send_byte(8'h1C, 0, 0); send_byte(8'h1C, 0, 0); send_byte(8'h66, 0, 0);
        cpu_addr = AW'(1); #1;
        check_eq("s3_cell1", 32'(o_cpu[0]), 32'h20);
        check_eq("s3_cursor1", 32'(o_cur[0]), 32'd1);
        send_byte(8'h66, 0, 0); send_byte(8'h66, 0, 0);
        check_eq("s3_cursor0", 32'(o_cur[0]), 32'd0);
        scan_cells("s3");

        // fill the whole buffer, then one more write
        do_reset();
        for (int i = 0; i < CELLS; i++) send_byte(8'h1C, 0, 0);
        check_eq("s4_wrap_cursor", 32'(o_cur[0]), 32'd0);
        check_eq("s4_hold_cursor", 32'(o_cur[1]), 32'(CELLS - 1));
        check_eq("s4_full1", 32'(o_full[1]), 32'd1);
        send_byte(8'h1C, 0, 0);
        check_eq("s4_wrap_cursor2", 32'(o_cur[0]), 32'd1);
        check_eq("s4_drop_kv", 32'(o_kv[1]), 32'd0);
        check_eq("s4_full1b", 32'(o_full[1]), 32'd1);
        scan_cells("s4");
        send_byte(8'h5A, 0, 0); send_byte(8'h66, 0, 0); send_byte(8'h5A, 0, 0);

        // reset discards a pending E0; extended right; error handling
        do_reset();
        send_byte(8'hE0, 0, 0);
        do_reset();
        send_byte(8'h74, 0, 0);
        check_eq("s5_no_move", 32'(o_cur[0]), 32'd0);
        send_byte(8'hE0, 0, 0); send_byte(8'h74, 0, 0);
        check_eq("s5_right", 32'(o_cur[0]), 32'd1);
        send_byte(8'h55, 1, 0);
        check_eq("s5_errc", 32'(o_errc[0]), 32'd1);
        send_byte(8'hE0, 0, 0); send_byte(8'h1C, 1, 0); send_byte(8'h1C, 0, 0);
        check_eq("s5_idle_after_err", 32'(o_ascii[0]), 32'h61);
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), 1, 0);
        check_eq("s5_errc_sat", 32'(o_errc[1]), 32'd255);

        // clear coinciding with a write
        send_byte(8'h1C, 0, 0);
        send_byte(8'h1C, 0, 1);
        scan_cells("s6");
        send_byte(8'h5A, 0, 0); send_byte(8'h2D, 0, 0);
        pulse_clear();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) pulse_clear();
            send_byte(rand_byte(), $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
            if (n % 100 == 99) scan_cells($sformatf("rnd%0d", n));
        end
        scan_cells("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
